toggle_monitor: RTL and testbench
=================================

Name: toggle_monitor

Overview:
- Passive receiving-end checker for the toggle flip-flop output interface (en, q, z).
- Samples the enable and both complementary outputs every clock and predicts the next q from the previous sample.
- Flags complement and sequence violations, counts confirmed toggles, and captures the cycle of the first failure.
- Instantiated beside the toggle source in benches and in silicon debug builds.

Parameters:
CNT_W, 16, width of the toggle counter, the cycle counter and the error-cycle capture register
SYNC_CYCLES, 2, number of consecutive complementary samples required before checking starts (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of counters, error state and lock; returns the FSM to UNSYNC
en_obs  input  1  observed enable of the source
q_obs  input  1  observed q output of the source
z_obs  input  1  observed z (complement) output of the source
locked  output  1  high while the FSM is in TRACK
state  output  2  FSM state: 00 UNSYNC, 01 SYNC, 10 TRACK, 11 ERROR
toggle_cnt  output  CNT_W  confirmed toggles since lock; saturating
err_pulse  output  1  single-cycle pulse on error detection
err_sticky  output  1  set on the first error; held until clr or reset
err_code  output  2  00 none, 01 complement, 10 sequence, 11 both
err_cycle  output  CNT_W  value of cyc_cnt at the first error

Behaviour:
- Reset (async, reset=0): all outputs 0, state=UNSYNC, and internal sync_cnt, cyc_cnt, prev_q and prev_en all 0.
- Sampling:
  - Inputs are sampled at each rising clk edge.
  - prev_q and prev_en are loaded with q_obs and en_obs on every edge, in every state.
- Complement check: comp_ok = (q_obs != z_obs).
- Sequence check: seq_ok = (q_obs == prev_q ^ prev_en).
- UNSYNC: on the next edge go to SYNC with sync_cnt=0. No checks are performed.
- SYNC:
  - comp_ok=1: sync_cnt increments.
  - comp_ok=0: sync_cnt returns to 0. No error is raised.
  - When sync_cnt reaches SYNC_CYCLES: go to TRACK, locked=1, cyc_cnt=0.
- TRACK:
  - cyc_cnt increments every cycle, saturating at all-ones.
  - Both checks are evaluated each cycle.
  - Both pass and prev_en=1: toggle_cnt increments, saturating at all-ones.
  - Any check fails, on that edge:
    - state goes to ERROR; locked=0.
    - err_pulse=1 for exactly one cycle.
    - err_sticky=1.
    - err_code = {~seq_ok, ~comp_ok}.
    - err_cycle = cyc_cnt before increment.
- ERROR:
  - No checking. Counters and error registers are frozen. err_pulse=0.
  - Leaves only via clr or reset.
- clr:
  - Has priority over all FSM transitions in every state.
  - Next edge: state=UNSYNC, and all counters, err_* and locked are cleared.
  - prev_q and prev_en still load normally.
- Simultaneous events:
  - Complement and sequence failures on the same sample give err_code=11.
  - Error with clr on the same edge: clr wins; no pulse, no sticky.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock. Checking resumes only after a fresh SYNC.
- Latency: a violation on the sample taken at edge N is visible on err_pulse and err_sticky after edge N.
- No output depends combinationally on any input.

Test Plan:
- Reset low 12 ns, then high, with q=0, z=1, en=0 -> state passes UNSYNC→SYNC→TRACK within 4 clocks; locked=1; toggle_cnt=0; err_sticky=0.
- Locked, then en=1 for 5 cycles with a correct source, then en=0 for 3 cycles -> toggle_cnt=5 and held; err_pulse never asserted.
- Locked, cyc_cnt=7, force z_obs=q_obs=1 for one sample with q sequence correct -> err_code=01, err_cycle=7, state=ERROR, err_pulse high for one cycle, err_sticky stays 1.
- Locked, en=0, flip q and z together (still complementary) -> err_code=10. Same step with z not flipped -> err_code=11.
- In ERROR, assert clr for one cycle -> all counters and err_* = 0, state=UNSYNC, relock after SYNC_CYCLES+1 clocks. Repeat with clr coincident with a violation -> no error recorded.
- CNT_W=3, continuous toggling for 12 cycles -> toggle_cnt saturates at 7. Then drop reset asynchronously mid-clock -> outputs 0 before the next clk edge.

Source files
------------

// File: rtl/toggle_monitor.sv
// rtl/toggle_monitor.sv - passive checker for a toggle flip-flop (en, q, z) interface
module toggle_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en_obs,
    input  logic             q_obs,
    input  logic             z_obs,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cycle
);

    typedef enum logic [1:0] {
        UNSYNC = 2'b00,
        SYNC   = 2'b01,
        TRACK  = 2'b10,
        ERROR  = 2'b11
    } state_t;

    localparam logic [3:0]       SYNC_TGT = 4'(SYNC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       sync_cnt_q, sync_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_cycle_q, err_cycle_d;
    logic             prev_q_q, prev_q_d;
    logic             prev_en_q, prev_en_d;

    logic       comp_ok;
    logic       seq_ok;
    logic [3:0] sync_next;

    assign comp_ok = q_obs ^ z_obs;
    assign seq_ok  = (q_obs == (prev_q_q ^ prev_en_q));

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
        err_cycle_d  = err_cycle_q;
        prev_q_d     = q_obs;
        prev_en_d    = en_obs;
        sync_next    = comp_ok ? (sync_cnt_q + 4'd1) : 4'd0;

        if (clr) begin
            state_d      = UNSYNC;
            sync_cnt_d   = '0;
            cyc_cnt_d    = '0;
            toggle_cnt_d = '0;
            err_sticky_d = 1'b0;
            err_code_d   = 2'b00;
            err_cycle_d  = '0;
        end else begin
            case (state_q)
                UNSYNC: begin
                    state_d    = SYNC;
                    sync_cnt_d = '0;
                end
                SYNC: begin
                    sync_cnt_d = sync_next;
                    if (sync_next == SYNC_TGT) begin
                        state_d      = TRACK;
                        cyc_cnt_d    = '0;
                        toggle_cnt_d = '0;
                    end
                end
                TRACK: begin
                    if (cyc_cnt_q != CNT_MAX) begin
                        cyc_cnt_d = cyc_cnt_q + CNT_ONE;
                    end
                    if (!comp_ok || !seq_ok) begin
                        state_d      = ERROR;
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        err_code_d   = {~seq_ok, ~comp_ok};
                        err_cycle_d  = cyc_cnt_q;
                    end else if (prev_en_q && (toggle_cnt_q != CNT_MAX)) begin
                        toggle_cnt_d = toggle_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    // ERROR holds everything until clr or reset
                    state_d = ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= UNSYNC;
            sync_cnt_q   <= '0;
            cyc_cnt_q    <= '0;
            toggle_cnt_q <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_code_q   <= 2'b00;
            err_cycle_q  <= '0;
            prev_q_q     <= 1'b0;
            prev_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_code_q   <= err_code_d;
            err_cycle_q  <= err_cycle_d;
            prev_q_q     <= prev_q_d;
            prev_en_q    <= prev_en_d;
        end
    end

    assign locked     = (state_q == TRACK);
    assign state      = state_q;
    assign toggle_cnt = toggle_cnt_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_code   = err_code_q;
    assign err_cycle  = err_cycle_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// tb/tb_toggle_monitor.sv - directed self-checking bench for toggle_monitor
module tb_toggle_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_s = 1'b1;
    logic        clr = 1'b0;
    logic        en_obs = 1'b0;
    logic        q_obs = 1'b0;
    logic        z_obs = 1'b1;

    logic        locked;
    logic [1:0]  state;
    logic [15:0] toggle_cnt;
    logic        err_pulse;
    logic        err_sticky;
    logic [1:0]  err_code;
    logic [15:0] err_cycle;

    logic        locked_s;
    logic [1:0]  state_s;
    logic [2:0]  toggle_cnt_s;
    logic        err_pulse_s;
    logic        err_sticky_s;
    logic [1:0]  err_code_s;
    logic [2:0]  err_cycle_s;

    int n_assert = 0;
    int n_fail   = 0;
    logic qm = 1'b0;

    toggle_monitor #(.CNT_W(16), .SYNC_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .en_obs(en_obs), .q_obs(q_obs), .z_obs(z_obs),
        .locked(locked), .state(state), .toggle_cnt(toggle_cnt),
        .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_code(err_code), .err_cycle(err_cycle)
    );

    toggle_monitor #(.CNT_W(3), .SYNC_CYCLES(2)) dut_s (
        .clk(clk), .reset(reset_s), .clr(clr),
        .en_obs(en_obs), .q_obs(q_obs), .z_obs(z_obs),
        .locked(locked_s), .state(state_s), .toggle_cnt(toggle_cnt_s),
        .err_pulse(err_pulse_s), .err_sticky(err_sticky_s),
        .err_code(err_code_s), .err_cycle(err_cycle_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Apply one sample, clock it, and advance the reference q of a correct source.
    task automatic drive(input logic e, input logic q, input logic z, input logic c);
        en_obs = e;
        q_obs  = q;
        z_obs  = z;
        clr    = c;
        @(posedge clk);
        #1;
        qm = q ^ e;
    endtask

    task automatic good(input logic e, input logic c);
        drive(e, qm, ~qm, c);
    endtask

    task automatic relock;
        good(1'b0, 1'b1);
        good(1'b0, 1'b0);
        good(1'b0, 1'b0);
        good(1'b0, 1'b0);
    endtask

    initial begin
        #1 reset = 1'b0; reset_s = 1'b0;
        #9;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_toggle", 32'(toggle_cnt), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        #3 reset = 1'b1; reset_s = 1'b1;

        good(1'b0, 1'b0);
        chk("sync_state1", 32'(state), 32'd1);
        good(1'b0, 1'b0);
        chk("sync_state2", 32'(state), 32'd1);
        good(1'b0, 1'b0);
        chk("lock_state", 32'(state), 32'd2);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_toggle", 32'(toggle_cnt), 32'd0);
        chk("lock_sticky", 32'(err_sticky), 32'd0);

        for (int i = 0; i < 5; i++) begin
            good(1'b1, 1'b0);
            chk("tog_no_pulse", 32'(err_pulse), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            good(1'b0, 1'b0);
            chk("tog_no_pulse", 32'(err_pulse), 32'd0);
        end
        chk("tog_cnt5", 32'(toggle_cnt), 32'd5);
        good(1'b0, 1'b0);
        chk("tog_cnt_held", 32'(toggle_cnt), 32'd5);

        // Complement failure at cyc_cnt = 7 after a fresh lock
        relock;
        chk("relock_a", 32'(state), 32'd2);
        for (int i = 0; i < 7; i++) good(1'b0, 1'b0);
        chk("pre_err_q", 32'(qm), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("comp_code", 32'(err_code), 32'd1);
        chk("comp_cycle", 32'(err_cycle), 32'd7);
        chk("comp_state", 32'(state), 32'd3);
        chk("comp_locked", 32'(locked), 32'd0);
        chk("comp_pulse", 32'(err_pulse), 32'd1);
        chk("comp_sticky", 32'(err_sticky), 32'd1);
        good(1'b1, 1'b0);
        chk("comp_pulse_off", 32'(err_pulse), 32'd0);
        chk("comp_sticky_hold", 32'(err_sticky), 32'd1);
        chk("comp_state_hold", 32'(state), 32'd3);
        chk("comp_code_hold", 32'(err_code), 32'd1);

        // clr out of ERROR, then relock in SYNC_CYCLES+1 clocks
        good(1'b0, 1'b1);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_toggle", 32'(toggle_cnt), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        chk("clr_cycle", 32'(err_cycle), 32'd0);
        chk("clr_pulse", 32'(err_pulse), 32'd0);
        good(1'b0, 1'b0);
        good(1'b0, 1'b0);
        chk("clr_relock_sync", 32'(state), 32'd1);
        good(1'b0, 1'b0);
        chk("clr_relock_track", 32'(state), 32'd2);

        // Sequence-only failure: q and z flipped together
        drive(1'b0, ~qm, qm, 1'b0);
        chk("seq_code", 32'(err_code), 32'd2);
        chk("seq_pulse", 32'(err_pulse), 32'd1);

        // Both failures: q flipped, z left alone
        relock;
        chk("relock_b", 32'(state), 32'd2);
        drive(1'b0, ~qm, ~qm, 1'b0);
        chk("both_code", 32'(err_code), 32'd3);
        chk("both_state", 32'(state), 32'd3);

        // Violation coincident with clr: clr wins
        relock;
        drive(1'b0, ~qm, ~qm, 1'b1);
        chk("clrwin_state", 32'(state), 32'd0);
        chk("clrwin_pulse", 32'(err_pulse), 32'd0);
        chk("clrwin_sticky", 32'(err_sticky), 32'd0);
        chk("clrwin_code", 32'(err_code), 32'd0);

        // Saturation of a 3-bit toggle counter
        relock;
        chk("sat_locked", 32'(locked_s), 32'd1);
        for (int i = 0; i < 13; i++) good(1'b1, 1'b0);
        chk("sat_cnt", 32'(toggle_cnt_s), 32'd7);
        chk("wide_cnt", 32'(toggle_cnt), 32'd12);
        chk("sat_no_err", 32'(err_sticky_s), 32'd0);

        // Asynchronous reset mid-clock
        #2 reset_s = 1'b0;
        #1;
        chk("async_cnt", 32'(toggle_cnt_s), 32'd0);
        chk("async_state", 32'(state_s), 32'd0);
        chk("async_locked", 32'(locked_s), 32'd0);
        #1 reset_s = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
